// File: rtl/frv_mem_arbiter.sv
// Two-requester (instruction/data) arbiter in front of one FRV memory port.
// Owner FIFO routes in-order responses back to whichever requester was granted.
module frv_mem_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter bit          RR_EN = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        i_req,
    input  logic        i_wen,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_recv,
    input  logic        i_ack,
    output logic        i_error,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wen,
    input  logic [3:0]  d_strb,
    input  logic [31:0] d_wdata,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_recv,
    input  logic        d_ack,
    output logic        d_error,
    output logic [31:0] d_rdata,

    output logic        mem_req,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic        mem_error,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] FULL_CNT = 4'(DEPTH);
    localparam logic [2:0] PTR_LAST = 3'(DEPTH - 1);

    typedef enum logic [1:0] {LK_NONE, LK_INSTR, LK_DATA} lock_t;

    lock_t       lock_q, lock_d;
    logic        last_data_q;
    logic [3:0]  count_q;
    logic [2:0]  wr_ptr_q, rd_ptr_q;
    logic [7:0]  owner_q;

    logic        sel_vld, sel_data, sel_req;
    logic        full, head_vld, head_data, push, pop;

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = 1'b0;
        case (lock_q)
            LK_INSTR: begin sel_vld = 1'b1; sel_data = 1'b0; end
            LK_DATA:  begin sel_vld = 1'b1; sel_data = 1'b1; end
            default: begin
                if (i_req && d_req) begin
                    sel_vld  = 1'b1;
                    sel_data = RR_EN ? ~last_data_q : 1'b1;
                end else if (i_req || d_req) begin
                    sel_vld  = 1'b1;
                    sel_data = d_req;
                end
            end
        endcase
        // Reset forces every output low even with requesters still driving
        sel_vld = sel_vld && g_resetn;
    end

    assign sel_req   = sel_data ? d_req : i_req;
    assign full      = (count_q == FULL_CNT);
    assign head_vld  = (count_q != 4'd0) && g_resetn;
    assign head_data = owner_q[rd_ptr_q];

    always_comb begin
        mem_req   = sel_vld && sel_req && !full;
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_wdata = '0;
        mem_addr  = '0;
        if (sel_vld) begin
            mem_wen   = sel_data ? d_wen   : i_wen;
            mem_strb  = sel_data ? d_strb  : i_strb;
            mem_wdata = sel_data ? d_wdata : i_wdata;
            mem_addr  = sel_data ? d_addr  : i_addr;
        end
    end

    assign push    = mem_req && mem_gnt;
    assign i_gnt   = push && !sel_data;
    assign d_gnt   = push &&  sel_data;

    assign mem_ack = head_vld && (head_data ? d_ack : i_ack);
    assign pop     = mem_recv && mem_ack;
    assign i_recv  = head_vld && !head_data && mem_recv;
    assign d_recv  = head_vld &&  head_data && mem_recv;
    assign i_error = i_recv && mem_error;
    assign d_error = d_recv && mem_error;
    assign i_rdata = g_resetn ? mem_rdata : '0;
    assign d_rdata = g_resetn ? mem_rdata : '0;

    always_comb begin
        lock_d = lock_q;
        if (push)
            lock_d = LK_NONE;
        else if (mem_req)
            lock_d = sel_data ? LK_DATA : LK_INSTR;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_q      <= LK_NONE;
            last_data_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            owner_q     <= '0;
        end else begin
            lock_q <= lock_d;
            if (push) begin
                owner_q[wr_ptr_q] <= sel_data;
                last_data_q       <= sel_data;
                wr_ptr_q          <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 3'd1;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 3'd1;
            if (push && !pop)
                count_q <= count_q + 4'd1;
            else if (pop && !push)
                count_q <= count_q - 4'd1;
        end
    end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter with a queue-based reference model checked every cycle.
module tb_frv_mem_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam bit          RR_EN = 1'b1;

    logic        g_clk, g_resetn;
    logic        i_req, i_wen, i_ack, d_req, d_wen, d_ack;
    logic [3:0]  i_strb, d_strb;
    logic [31:0] i_wdata, i_addr, d_wdata, d_addr;
    logic        i_gnt, i_recv, i_error, d_gnt, d_recv, d_error;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_req, mem_wen, mem_ack, mem_gnt, mem_recv, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    frv_mem_arbiter #(.DEPTH(DEPTH), .RR_EN(RR_EN)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .i_req(i_req), .i_wen(i_wen), .i_strb(i_strb), .i_wdata(i_wdata), .i_addr(i_addr),
        .i_gnt(i_gnt), .i_recv(i_recv), .i_ack(i_ack), .i_error(i_error), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_strb(d_strb), .d_wdata(d_wdata), .d_addr(d_addr),
        .d_gnt(d_gnt), .d_recv(d_recv), .d_ack(d_ack), .d_error(d_error), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(mem_ack),
        .mem_error(mem_error), .mem_rdata(mem_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int vectors = 0;
    int miscompares = 0;
    bit run_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of owners (0=instr, 1=data), last winner, lock owner (-1 none)
    int q[$];
    int m_last = 0;
    int m_lock = -1;
    int e_who;
    logic        e_mem_req, e_mem_wen, e_mem_ack;
    logic [3:0]  e_mem_strb;
    logic [31:0] e_mem_wdata, e_mem_addr, e_rdata;
    logic        e_i_gnt, e_d_gnt, e_i_recv, e_d_recv, e_i_err, e_d_err;

    function automatic void eval();
        int who;
        int head;
        who = -1;
        if (m_lock >= 0) who = m_lock;
        else if (i_req && d_req) who = RR_EN ? 1 - m_last : 1;
        else if (d_req) who = 1;
        else if (i_req) who = 0;
        head = (q.size() > 0) ? q[0] : -1;
        e_who = who;
        e_mem_req = 0; e_mem_wen = 0; e_mem_ack = 0; e_mem_strb = '0;
        e_mem_wdata = '0; e_mem_addr = '0; e_rdata = '0;
        e_i_gnt = 0; e_d_gnt = 0; e_i_recv = 0; e_d_recv = 0; e_i_err = 0; e_d_err = 0;
        if (g_resetn) begin
            e_rdata = mem_rdata;
            if (who == 1) begin
                e_mem_req = d_req && (q.size() < DEPTH);
                e_mem_wen = d_wen; e_mem_strb = d_strb; e_mem_wdata = d_wdata; e_mem_addr = d_addr;
                e_d_gnt = e_mem_req && mem_gnt;
            end else if (who == 0) begin
                e_mem_req = i_req && (q.size() < DEPTH);
                e_mem_wen = i_wen; e_mem_strb = i_strb; e_mem_wdata = i_wdata; e_mem_addr = i_addr;
                e_i_gnt = e_mem_req && mem_gnt;
            end
            if (head == 1) begin
                e_mem_ack = d_ack; e_d_recv = mem_recv; e_d_err = mem_recv && mem_error;
            end else if (head == 0) begin
                e_mem_ack = i_ack; e_i_recv = mem_recv; e_i_err = mem_recv && mem_error;
            end
        end
    endfunction

    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            q.delete();
            m_last = 0;
            m_lock = -1;
        end else begin
            bit push, pop;
            eval();
            push = e_mem_req && mem_gnt;
            pop  = mem_recv && e_mem_ack;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e_who);
                m_last = e_who;
                m_lock = -1;
            end else if (e_mem_req) begin
                m_lock = e_who;
            end
        end
    end

    always @(negedge g_clk) begin
        if (run_chk) begin
            eval();
            chk("mem_req", mem_req, e_mem_req);
            chk("mem_wen", mem_wen, e_mem_wen);
            chk("mem_strb", mem_strb, e_mem_strb);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_ack", mem_ack, e_mem_ack);
            chk("i_gnt", i_gnt, e_i_gnt);
            chk("d_gnt", d_gnt, e_d_gnt);
            chk("i_recv", i_recv, e_i_recv);
            chk("d_recv", d_recv, e_d_recv);
            chk("i_error", i_error, e_i_err);
            chk("d_error", d_error, e_d_err);
            chk("i_rdata", i_rdata, e_rdata);
            chk("d_rdata", d_rdata, e_rdata);
        end
    end

    task automatic idle();
        i_req = 0; i_wen = 0; i_strb = 4'h0; i_wdata = '0; i_addr = '0; i_ack = 0;
        d_req = 0; d_wen = 0; d_strb = 4'h0; d_wdata = '0; d_addr = '0; d_ack = 0;
        mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = '0;
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    int exp_dg[4] = '{1, 0, 1, 0};
    int exp_dr[4] = '{0, 1, 0, 1};
    int exp_ir[4] = '{0, 0, 1, 0};

    initial begin
        idle();
        g_resetn = 1'b0;
        run_chk  = 1'b1;
        repeat (2) @(posedge g_clk);
        #1;
        i_req = 1; d_req = 1; mem_gnt = 1; mem_recv = 1; i_ack = 1; d_ack = 1;
        i_addr = 32'h1111_0000; mem_rdata = 32'hA5A5_A5A5;
        @(negedge g_clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        cyc();
        idle();
        g_resetn = 1'b1;

        // Tie with grants and responses every cycle: d,i,d,i from reset, FIFO order kept
        i_req = 1; d_req = 1; mem_gnt = 1; mem_recv = 1; i_ack = 1; d_ack = 1;
        i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        i_wdata = 32'h1111_1111; d_wdata = 32'h2222_2222; i_strb = 4'h3; d_strb = 4'hC; d_wen = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge g_clk);
            chk("rr_d_gnt", d_gnt, 32'(exp_dg[k]));
            chk("rr_addr", mem_addr, exp_dg[k] == 1 ? 32'h2000 : 32'h1000);
            chk("rr_d_recv", d_recv, 32'(exp_dr[k]));
            chk("rr_i_recv", i_recv, 32'(exp_ir[k]));
            cyc();
        end
        i_req = 0; d_req = 0; mem_gnt = 0;
        @(negedge g_clk);
        chk("drain_i_recv", i_recv, 1);
        cyc();
        @(negedge g_clk);
        chk("empty_mem_ack", mem_ack, 0);
        chk("empty_recv", {31'd0, i_recv | d_recv}, 0);
        cyc();

        // Lock: i stalled, d rises, address must hold until i_gnt
        idle();
        i_req = 1; i_addr = 32'h0000_3000; d_addr = 32'h0000_4000;
        @(negedge g_clk);
        chk("lock_req", mem_req, 1);
        chk("lock_addr0", mem_addr, 32'h3000);
        cyc();
        d_req = 1;
        @(negedge g_clk);
        chk("lock_addr1", mem_addr, 32'h3000);
        chk("lock_d_gnt", d_gnt, 0);
        cyc();
        @(negedge g_clk);
        chk("lock_addr2", mem_addr, 32'h3000);
        cyc();
        mem_gnt = 1;
        @(negedge g_clk);
        chk("lock_i_gnt", i_gnt, 1);
        chk("lock_addr3", mem_addr, 32'h3000);
        cyc();
        @(negedge g_clk);
        chk("after_d_gnt", d_gnt, 1);
        chk("after_addr", mem_addr, 32'h4000);
        cyc();

        // Full FIFO blocks d; error response routed to i
        i_req = 0; mem_gnt = 0; mem_recv = 1; mem_rdata = 32'hDEAD_BEEF; mem_error = 1;
        i_ack = 1; d_ack = 1;
        @(negedge g_clk);
        chk("full_mem_req", mem_req, 0);
        chk("resp_i_recv", i_recv, 1);
        chk("resp_i_error", i_error, 1);
        chk("resp_d_recv", d_recv, 0);
        chk("resp_i_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("resp_d_rdata", d_rdata, 32'hDEAD_BEEF);
        cyc();
        mem_error = 0; mem_rdata = 32'h1234_5678; d_ack = 0;
        @(negedge g_clk);
        chk("reassert_req", mem_req, 1);
        chk("resp2_d_recv", d_recv, 1);
        chk("resp2_mem_ack", mem_ack, 0);
        cyc();
        d_ack = 1; mem_gnt = 1;
        @(negedge g_clk);
        chk("pushpop_ack", mem_ack, 1);
        chk("pushpop_gnt", d_gnt, 1);
        cyc();
        mem_recv = 0; d_req = 0; i_req = 1;
        @(negedge g_clk);
        chk("fill_i_gnt", i_gnt, 1);
        cyc();

        // Reset while full with requests, responses and grants all driven high
        d_req = 1; mem_gnt = 0;
        @(negedge g_clk);
        chk("full2_mem_req", mem_req, 0);
        #2;
        g_resetn = 0; mem_recv = 1; mem_gnt = 1; mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_d_gnt", d_gnt, 0);
        chk("arst_mem_ack", mem_ack, 0);
        chk("arst_d_recv", d_recv, 0);
        chk("arst_d_rdata", d_rdata, 0);
        chk("arst_mem_addr", mem_addr, 0);
        repeat (2) @(posedge g_clk);
        #1;
        idle();
        g_resetn = 1;
        i_req = 1; d_req = 1; mem_gnt = 1; i_addr = 32'h0000_5000; d_addr = 32'h0000_6000;
        @(negedge g_clk);
        chk("post_rst_d_gnt", d_gnt, 1);
        chk("post_rst_i_gnt", i_gnt, 0);
        chk("post_rst_addr", mem_addr, 32'h6000);
        cyc();
        @(negedge g_clk);
        chk("post_rst_i_gnt2", i_gnt, 1);
        cyc();
        idle();
        repeat (2) cyc();
        run_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
